mpsubtractor: RTL and testbench

MPSUBTRACTOR -- requirements
Module: mpsubtractor

---
 rtl/mpsubtractor_pkg.sv | 15 +
 rtl/mpsubtractor_sub_blk.sv | 16 +
 rtl/mpsubtractor.sv | 160 ++++++++++++++++
 tb/tb_mpsubtractor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpsubtractor_pkg.sv
// Shared constants and FSM state encoding for the two-stage multi-precision subtractor.
package mpsubtractor_pkg;

    localparam int WIDTH = 1028;
    localparam int BLK   = 128;
    localparam int NBLK  = 8;
    localparam int TOP_W = 132;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t STAGE = 2'd1;
    localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/mpsubtractor_sub_blk.sv
// One carry-select block: difference and borrow-out for both possible borrow-in values.
module sub_blk #(
    parameter int W = 128
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff0,
    output logic         borrow0,
    output logic [W-1:0] diff1,
    output logic         borrow1
);

    assign {borrow0, diff0} = {1'b0, a} - {1'b0, b};
    assign {borrow1, diff1} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, 1'b1};

endmodule

// File: rtl/mpsubtractor.sv
// Two-stage carry-select subtractor: stage 1 registers per-block difference pairs,
// stage 2 resolves the block borrow chain and registers result/borrow.
module mpsubtractor #(
    parameter int WIDTH = mpsubtractor_pkg::WIDTH,
    parameter int BLK   = mpsubtractor_pkg::BLK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             csub,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic             busy,
    output logic             done,
    output logic [15:0]      prediction
);
    import mpsubtractor_pkg::*;

    // The top block absorbs the remainder bits (132 for the default widths).
    localparam int NB   = WIDTH / BLK;
    localparam int TOPW = WIDTH - (NB - 1) * BLK;

    state_t state_reg;
    state_t state_next;

    logic             load;
    logic [WIDTH-1:0] a_reg;
    logic             csub_reg;
    logic [WIDTH-1:0] result_reg;
    logic             borrow_reg;

    logic [NB-1:0]    b0_vec;
    logic [NB-1:1]    b1_vec;
    logic [NB-1:1]    sel;
    logic             borrow_next;
    logic [WIDTH-1:0] diff_sel;

    assign load = (state_reg == IDLE) && start;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = STAGE;
            STAGE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            csub_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                a_reg    <= in_a;
                csub_reg <= csub;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_blk
            localparam int LO = gi * BLK;
            localparam int W  = (gi == NB - 1) ? TOPW : BLK;

            logic [W-1:0] d0;
            logic         bo0;
            logic [W-1:0] d0_reg;
            logic         b0_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    d0_reg <= '0;
                    b0_reg <= 1'b0;
                end else if (load) begin
                    d0_reg <= d0;
                    b0_reg <= bo0;
                end
            end

            assign b0_vec[gi] = b0_reg;

            if (gi == 0) begin : g_first
                // Block 0 always sees borrow-in 0, so its borrow-in-1 pair is dropped.
                logic [W-1:0] d1_unused;
                logic         bo1_unused;

                sub_blk #(.W(W)) u_sub (
                    .a       (in_a[LO +: W]),
                    .b       (in_b[LO +: W]),
                    .diff0   (d0),
                    .borrow0 (bo0),
                    .diff1   (d1_unused),
                    .borrow1 (bo1_unused)
                );

                assign diff_sel[LO +: W] = d0_reg;
            end else begin : g_rest
                logic [W-1:0] d1;
                logic         bo1;
                logic [W-1:0] d1_reg;
                logic         b1_reg;

                sub_blk #(.W(W)) u_sub (
                    .a       (in_a[LO +: W]),
                    .b       (in_b[LO +: W]),
                    .diff0   (d0),
                    .borrow0 (bo0),
                    .diff1   (d1),
                    .borrow1 (bo1)
                );

                always_ff @(posedge clk) begin
                    if (reset) begin
                        d1_reg <= '0;
                        b1_reg <= 1'b0;
                    end else if (load) begin
                        d1_reg <= d1;
                        b1_reg <= bo1;
                    end
                end

                assign b1_vec[gi]        = b1_reg;
                assign diff_sel[LO +: W] = sel[gi] ? d1_reg : d0_reg;
            end
        end
    endgenerate

    // Borrow ripple across blocks uses only registered borrow-outs: one mux per block.
    always_comb begin
        sel         = '0;
        borrow_next = b0_vec[0];
        for (int i = 1; i < NB; i++) begin
            sel[i]      = borrow_next;
            borrow_next = borrow_next ? b1_vec[i] : b0_vec[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_reg <= '0;
            borrow_reg <= 1'b0;
        end else if (state_reg == STAGE) begin
            borrow_reg <= borrow_next;
            result_reg <= (csub_reg && borrow_next) ? a_reg : diff_sel;
        end
    end

    assign result     = result_reg;
    assign borrow     = borrow_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign prediction = in_a[15:0] - in_b[15:0];

endmodule

// File: tb/tb_mpsubtractor.sv
// Directed and random checks of mpsubtractor against a wide-integer golden model.
module tb_mpsubtractor;
    localparam int W = 1028;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         csub;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] result;
    logic         borrow;
    logic         busy;
    logic         done;
    logic [15:0]  prediction;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mpsubtractor dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .csub       (csub),
        .in_a       (in_a),
        .in_b       (in_b),
        .result     (result),
        .borrow     (borrow),
        .busy       (busy),
        .done       (done),
        .prediction (prediction)
    );

    task automatic chk_w(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs_hi=%h obs_lo=%h exp_hi=%h exp_lo=%h",
                   tag, obs[W-1:W-64], obs[63:0], exp[W-1:W-64], exp[63:0]);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_p(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < 33; i++) v = {v[W-33:0], 32'($urandom())};
        return v;
    endfunction

    // Golden model: plain unsigned arithmetic one bit wider than the operands.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cs,
                          input string tag, input bit verbose);
        logic [W:0]   g;
        logic [W-1:0] exp_r;
        logic         exp_b;
        g     = {1'b0, a} - {1'b0, b};
        exp_b = g[W];
        exp_r = (cs && exp_b) ? a : g[W-1:0];
        in_a  = a;
        in_b  = b;
        csub  = cs;
        start = 1'b1;
        #1;
        chk_p({tag, "/pred"}, prediction, g[15:0]);
        tick();
        start = 1'b0;
        in_a  = rnd();
        in_b  = rnd();
        csub  = ~cs;
        chk_b({tag, "/stage_busy"}, busy, 1'b1);
        chk_b({tag, "/stage_done"}, done, 1'b0);
        tick();
        chk_b({tag, "/done"}, done, 1'b1);
        chk_b({tag, "/done_busy"}, busy, 1'b1);
        chk_w({tag, "/result"}, result, exp_r);
        chk_b({tag, "/borrow"}, borrow, exp_b);
        tick();
        chk_b({tag, "/idle_done"}, done, 1'b0);
        chk_b({tag, "/idle_busy"}, busy, 1'b0);
        chk_w({tag, "/hold_result"}, result, exp_r);
        chk_b({tag, "/hold_borrow"}, borrow, exp_b);
        if (verbose)
            $display("op %s csub=%0b a_lo=%h b_lo=%h res_lo=%h borrow=%0b",
                     tag, cs, a[31:0], b[31:0], result[31:0], borrow);
    endtask

    initial begin
        logic [W-1:0] t;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           dones;
        int           mode;

        reset = 1'b1;
        start = 1'b0;
        csub  = 1'b0;
        in_a  = '0;
        in_b  = '0;
        tick();
        tick();
        chk_w("reset/result", result, '0);
        chk_b("reset/borrow", borrow, 1'b0);
        chk_b("reset/busy", busy, 1'b0);
        chk_b("reset/done", done, 1'b0);
        reset = 1'b0;
        tick();

        run_op(W'(5), W'(3), 1'b0, "sub5m3", 1'b1);
        t = '0;
        t[W-1] = 1'b1;
        run_op(t, W'(1), 1'b0, "ripple_2p1027", 1'b1);
        run_op('0, W'(1), 1'b0, "zero_minus_one", 1'b1);
        run_op('0, W'(1), 1'b1, "zero_minus_one_csub", 1'b1);
        t = rnd();
        run_op(t, t, 1'b0, "equal", 1'b1);
        run_op(t, t, 1'b1, "equal_csub", 1'b1);
        run_op(W'(7), W'(9), 1'b1, "csub_7m9", 1'b1);
        run_op(W'(9), W'(7), 1'b1, "csub_9m7", 1'b1);
        run_op(W'(7), W'(9), 1'b0, "plain_7m9", 1'b1);

        // Reset wins over start in the same cycle.
        reset = 1'b1;
        start = 1'b1;
        in_a  = W'(11);
        in_b  = W'(1);
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk_b("rst_vs_start/busy", busy, 1'b0);
        chk_w("rst_vs_start/result", result, '0);
        $display("op rst_vs_start busy=%0b", busy);

        // Starts during STAGE and DONE are ignored.
        dones = 0;
        in_a  = W'(100);
        in_b  = W'(1);
        csub  = 1'b0;
        start = 1'b1;
        tick();
        in_a = W'(50);
        in_b = W'(7);
        chk_b("busy_start/stage_busy", busy, 1'b1);
        tick();
        if (done) dones++;
        chk_w("busy_start/result", result, W'(99));
        start = 1'b0;
        tick();
        if (done) dones++;
        tick();
        if (done) dones++;
        chk_b("busy_start/no_queue", busy, 1'b0);
        tick();
        if (done) dones++;
        chk_w("busy_start/done_count", W'(dones), W'(1));
        chk_w("busy_start/hold", result, W'(99));
        $display("op busy_start dones=%0d res_lo=%h", dones, result[31:0]);

        // Reset during STAGE aborts the operation.
        run_op(W'(5), W'(3), 1'b0, "pre_abort", 1'b0);
        in_a  = W'(10);
        in_b  = W'(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_w("abort/result", result, '0);
        chk_b("abort/borrow", borrow, 1'b0);
        chk_b("abort/busy", busy, 1'b0);
        chk_b("abort/done", done, 1'b0);
        tick();
        chk_b("abort/no_done", done, 1'b0);
        $display("op abort busy=%0b done=%0b", busy, done);
        run_op(W'(10), W'(4), 1'b0, "after_abort", 1'b1);

        // Start held high: one operation every 3 cycles.
        dones = 0;
        in_a  = W'(20);
        in_b  = W'(5);
        csub  = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (done) dones++;
        end
        start = 1'b0;
        chk_w("continuous/done_count", W'(dones), W'(3));
        chk_b("continuous/idle", busy, 1'b0);
        chk_w("continuous/result", result, W'(15));
        $display("op continuous dones=%0d", dones);

        for (int n = 0; n < 10000; n++) begin
            mode = $urandom_range(0, 3);
            ra   = rnd();
            rb   = rnd();
            case (mode)
                1:       rb = ra;
                2:       rb = ra + W'($urandom_range(0, 3)) - W'($urandom_range(0, 3));
                3:       begin
                             ra = ra & rnd() & rnd() & rnd();
                             rb = rb & rnd() & rnd() & rnd();
                         end
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
